// File: rtl/riscv_instruction_properties_pkg.sv
// riscv_instruction_properties: shared instruction enums, opcodes, name tables and the decoded-instruction record
package riscv_instruction_properties;
    localparam int MAX_XLEN = 64;

    typedef enum logic [5:0] {
        NOP, LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, LWU, LD, SB, SH, SW, SD,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW, SRAW,
        FENCE, FENCEI, ECALL, EBREAK, CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } riscv_instr_name_t;

    typedef enum logic [2:0] {
        R_FORMAT, I_FORMAT, I_FORMAT_SHIFT, S_FORMAT, B_FORMAT, U_FORMAT, J_FORMAT
    } riscv_instr_format_t;

    typedef enum logic [3:0] {
        LOAD, STORE, SHIFT, ARITHMETIC, LOGICAL, COMPARE, BRANCH, JUMP,
        SYNCH, SYSTEM, COUNTER, CSR, CHANGELEVEL, TRAP, INTERRUPT, AMO
    } riscv_instr_cateogry_t;

    typedef enum logic [4:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1, A0, A1, A2, A3, A4, A5, A6, A7,
        S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, T3, T4, T5, T6
    } riscv_reg_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam riscv_instr_name_t BRANCH_NAMES [8] = '{BEQ, BNE, NOP, NOP, BLT, BGE, BLTU, BGEU};
    localparam riscv_instr_name_t LOAD_NAMES   [8] = '{LB, LH, LW, LD, LBU, LHU, LWU, NOP};
    localparam riscv_instr_name_t STORE_NAMES  [8] = '{SB, SH, SW, SD, NOP, NOP, NOP, NOP};
    localparam riscv_instr_name_t OPIMM_NAMES  [8] = '{ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, ORI, ANDI};
    localparam riscv_instr_name_t OP_NAMES     [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
    localparam riscv_instr_name_t CSR_NAMES    [8] = '{NOP, CSRRW, CSRRS, CSRRC, NOP, CSRRWI, CSRRSI, CSRRCI};
    localparam riscv_instr_cateogry_t OP_CATS  [8] = '{ARITHMETIC, SHIFT, COMPARE, COMPARE, LOGICAL, SHIFT, LOGICAL, LOGICAL};

    typedef struct packed {
        riscv_instr_name_t     name;
        riscv_instr_format_t   format;
        riscv_instr_cateogry_t category;
        riscv_reg_t            rd;
        riscv_reg_t            rs1;
        riscv_reg_t            rs2;
        logic [MAX_XLEN-1:0]   imm;
        logic                  illegal;
    } riscv_decoded_instr_t;
endpackage

// File: rtl/riscv_instr_decode_comb.sv
// riscv_instr_decode_comb: purely combinational RV32I/RV64I instruction word to decoded record
module riscv_instr_decode_comb
    import riscv_instruction_properties::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    output riscv_decoded_instr_t dec
);
    localparam bit RV64 = (XLEN == 64);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic ok, shift_ok, wshift_ok;
    riscv_instr_name_t nm;
    riscv_instr_format_t fmt;
    riscv_instr_cateogry_t cat;

    assign opc = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shift_ok = (instr[31:26] == {1'b0, f3[2] & instr[30], 4'b0}) && (RV64 || !instr[25]);
    assign wshift_ok = instr[31:25] == {1'b0, f3[2] & instr[30], 5'b0};

    always_comb begin
        nm = NOP;
        fmt = I_FORMAT;
        cat = SYSTEM;
        imm = imm_i;
        ok = 1'b0;
        case (opc)
            OPC_LUI:   begin nm = LUI;   fmt = U_FORMAT; cat = ARITHMETIC; imm = imm_u; ok = 1'b1; end
            OPC_AUIPC: begin nm = AUIPC; fmt = U_FORMAT; cat = ARITHMETIC; imm = imm_u; ok = 1'b1; end
            OPC_JAL:   begin nm = JAL;   fmt = J_FORMAT; cat = JUMP;       imm = imm_j; ok = 1'b1; end
            OPC_JALR:  begin nm = JALR;  cat = JUMP; ok = f3 == 3'b000; end
            OPC_BRANCH: begin
                nm = BRANCH_NAMES[f3]; fmt = B_FORMAT; cat = BRANCH; imm = imm_b;
                ok = f3[2:1] != 2'b01;
            end
            OPC_LOAD: begin
                nm = LOAD_NAMES[f3]; cat = LOAD;
                ok = f3 != 3'b111 && (RV64 || (f3 != 3'b011 && f3 != 3'b110));
            end
            OPC_STORE: begin
                nm = STORE_NAMES[f3]; fmt = S_FORMAT; cat = STORE; imm = imm_s;
                ok = !f3[2] && (RV64 || f3 != 3'b011);
            end
            OPC_OP_IMM: begin
                nm = (instr == 32'h0000_0013) ? NOP : (f3 == 3'b101 && instr[30]) ? SRAI : OPIMM_NAMES[f3];
                cat = OP_CATS[f3];
                fmt = (f3[1:0] == 2'b01) ? I_FORMAT_SHIFT : I_FORMAT;
                imm = (f3[1:0] == 2'b01) ? {58'b0, instr[25:20]} : imm_i;
                ok = (f3[1:0] != 2'b01) || shift_ok;
            end
            OPC_OP_IMM_32: begin
                nm = (f3 == 3'b000) ? ADDIW : (f3 == 3'b001) ? SLLIW : instr[30] ? SRAIW : SRLIW;
                cat = (f3 == 3'b000) ? ARITHMETIC : SHIFT;
                fmt = (f3 == 3'b000) ? I_FORMAT : I_FORMAT_SHIFT;
                imm = (f3 == 3'b000) ? imm_i : {59'b0, instr[24:20]};
                ok = RV64 && (f3 == 3'b000 || (f3[1:0] == 2'b01 && wshift_ok));
            end
            OPC_OP: begin
                nm = f7[5] ? (f3[2] ? SRA : SUB) : OP_NAMES[f3];
                fmt = R_FORMAT; cat = OP_CATS[f3]; imm = '0;
                ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OP_32: begin
                nm = (f3 == 3'b001) ? SLLW : (f3 == 3'b101) ? (f7[5] ? SRAW : SRLW) : (f7[5] ? SUBW : ADDW);
                fmt = R_FORMAT; cat = (f3 == 3'b000) ? ARITHMETIC : SHIFT; imm = '0;
                ok = RV64 && (f3 == 3'b000 || f3[1:0] == 2'b01) && (f7 == 7'b0 || (f7 == 7'b0100000 && f3 != 3'b001));
            end
            OPC_MISC_MEM: begin nm = f3[0] ? FENCEI : FENCE; cat = SYNCH; ok = f3[2:1] == 2'b00; end
            OPC_SYSTEM: begin
                nm = (f3 == 3'b000) ? (instr[20] ? EBREAK : ECALL) : CSR_NAMES[f3];
                cat = (f3 == 3'b000) ? SYSTEM : CSR;
                imm = (f3 == 3'b000) ? imm_i : {52'b0, instr[31:20]};
                ok = (f3 == 3'b000) ? ({instr[31:21], instr[19:7]} == '0) : (f3 != 3'b100);
            end
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        dec = '0;
        dec.name = ok ? nm : NOP;
        dec.format = ok ? fmt : I_FORMAT;
        dec.category = ok ? cat : SYSTEM;
        dec.rd = (!ok || fmt == S_FORMAT || fmt == B_FORMAT) ? ZERO : riscv_reg_t'(instr[11:7]);
        dec.rs1 = (!ok || fmt == U_FORMAT || fmt == J_FORMAT) ? ZERO : riscv_reg_t'(instr[19:15]);
        dec.rs2 = (ok && (fmt == R_FORMAT || fmt == S_FORMAT || fmt == B_FORMAT)) ? riscv_reg_t'(instr[24:20]) : ZERO;
        dec.imm = ok ? imm : '0;
        dec.illegal = !ok;
    end
endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: buffered RV32I/RV64I decode stage with output FIFO and saturating per-category retire counters
module riscv_decode_stage
    import riscv_instruction_properties::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output riscv_instr_name_t     out_name,
    output riscv_instr_format_t   out_format,
    output riscv_instr_cateogry_t out_category,
    output riscv_reg_t            out_rd,
    output riscv_reg_t            out_rs1,
    output riscv_reg_t            out_rs2,
    output logic [XLEN-1:0]       out_imm,
    output logic                  out_illegal,
    input  logic                  cnt_clr,
    input  logic [3:0]            cnt_sel,
    output logic [CNT_W-1:0]      cnt_value
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        riscv_decoded_instr_t dec;
        logic [XLEN-1:0]      pc;
    } entry_t;

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    entry_t head;
    riscv_decoded_instr_t dec;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [CNT_W-1:0] cnt_q [16];
    logic [CNT_W-1:0] cnt_d [16];
    logic push, pop, unused_imm;

    riscv_instr_decode_comb #(.XLEN(XLEN)) u_decode (.instr(in_instr), .dec(dec));

    assign in_ready = count_q != (AW+1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign head = mem_q[rd_ptr_q];
    assign out_pc = head.pc;
    assign out_name = head.dec.name;
    assign out_format = head.dec.format;
    assign out_category = head.dec.category;
    assign out_rd = head.dec.rd;
    assign out_rs1 = head.dec.rs1;
    assign out_rs2 = head.dec.rs2;
    assign out_imm = head.dec.imm[XLEN-1:0];
    assign out_illegal = head.dec.illegal;
    assign unused_imm = ^head.dec.imm;
    assign cnt_value = cnt_q[cnt_sel];

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = '{dec: dec, pc: in_pc};
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        cnt_d = cnt_q;
        if (cnt_clr) cnt_d = '{default: '0};
        else if (pop && !head.dec.illegal && cnt_q[head.dec.category] != '1)
            cnt_d[head.dec.category] = cnt_q[head.dec.category] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            cnt_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
